// File: rtl/mem_b_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_b_reader: walks memory B from address 0 to DEPTH-1 and presents each  |
// | word on a valid/ready port. The optional checksum is READER_CHECKSUM_EN.  |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_b_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [DATA_W-1:0]        DataB,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        AddrB,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W+ADDR_W-1:0] sum
);

  localparam int c_SUM_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic                w_launch;
  logic                w_accept;
  logic                w_last;

  assign w_launch = (r_state == S_IDLE) && start;
  assign w_accept = (r_state == S_PRESENT) && out_ready;
  assign w_last   = (r_addr == c_LAST_ADDR);

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_FETCH;
      S_FETCH:   w_next_state = S_WAIT;
      S_WAIT:    w_next_state = S_PRESENT;
      S_PRESENT: if (out_ready) w_next_state = w_last ? S_DONE : S_FETCH;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Address moves only on edges that enter FETCH; it parks at the last word.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_addr     <= '0;
      r_out_data <= '0;
    end else begin
      if (w_launch) begin
        r_addr <= '0;
      end else if (w_accept && !w_last) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (r_state == S_WAIT) begin
        r_out_data <= DataB;
      end
    end
  end

`ifdef READER_CHECKSUM_EN
  logic [c_SUM_W-1:0] r_sum;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_sum <= '0;
    end else if (w_launch) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + c_SUM_W'(r_out_data);
    end
  end

  assign sum = r_sum;
`else
  assign sum = '0;
`endif

  assign AddrB     = r_addr;
  assign out_data  = r_out_data;
  assign out_valid = (r_state == S_PRESENT);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_b_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_b_reader: directed bench for mem_b_reader (DEPTH=8 and DEPTH=1).    |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mem_b_reader;

`ifdef READER_CHECKSUM_EN
  localparam bit c_CK = 1'b1;
`else
  localparam bit c_CK = 1'b0;
`endif

  logic        clk;
  logic        Reset;
  logic        start;
  logic [7:0]  DataB;
  logic        out_ready;
  logic [2:0]  AddrB;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [10:0] sum;

  logic        start1;
  logic [7:0]  DataB1;
  logic        out_ready1;
  logic [2:0]  AddrB1;
  logic [7:0]  out_data1;
  logic        out_valid1;
  logic        busy1;
  logic        done1;
  logic [10:0] sum1;

  logic [7:0]  mem [8];
  int          n_assert;
  int          n_fail;

  mem_b_reader #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) u_dut (
    .clock(clk), .Reset(Reset), .start(start), .DataB(DataB), .out_ready(out_ready),
    .AddrB(AddrB), .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .done(done), .sum(sum)
  );

  mem_b_reader #(.DATA_W(8), .ADDR_W(3), .DEPTH(1)) u_dut1 (
    .clock(clk), .Reset(Reset), .start(start1), .DataB(DataB1), .out_ready(out_ready1),
    .AddrB(AddrB1), .out_data(out_data1), .out_valid(out_valid1), .busy(busy1),
    .done(done1), .sum(sum1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memories: data valid the cycle after the address.
  always @(posedge clk) DataB  <= mem[AddrB];
  always @(posedge clk) DataB1 <= (AddrB1 == 3'd0) ? 8'hA5 : 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle 1 (FETCH of word 0); returns in the IDLE cycle after DONE.
  task automatic run_pass(input string tag, input bit hold, input int stall_word,
                          input int stall_len, input int poke_cycle);
    int          words;
    int          dones;
    int          stalls;
    int          done_cycle;
    bit          fin;
    logic [10:0] model_sum;
    words = 0; dones = 0; stalls = 0; done_cycle = 0; fin = 1'b0; model_sum = '0;
    check({tag, "_first_addr"}, AddrB, 0);
    for (int c = 1; c <= 200 && !fin; c++) begin
      start     = hold || (c == poke_cycle);
      out_ready = 1'b1;
      check({tag, "_busy"}, busy, 1);
      if (out_valid) begin
        check({tag, "_addr"}, AddrB, words);
        check({tag, "_data"}, out_data, mem[words[2:0]]);
        if (words == stall_word && stalls < stall_len) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          model_sum = model_sum + 11'(mem[words[2:0]]);
          words++;
        end
      end
      if (done) begin
        dones++;
        done_cycle = c;
        fin = 1'b1;
      end
      tick();
    end
    check({tag, "_timeout"}, fin, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_valid"}, out_valid, 0);
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_words"}, words, 8);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_stalls"}, stalls, (stall_word >= 0) ? stall_len : 0);
    check({tag, "_done_cycle"}, done_cycle, 25 + ((stall_word >= 0) ? stall_len : 0));
    check({tag, "_sum"}, sum, c_CK ? model_sum : 11'h000);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    Reset = 1'b1; start = 1'b0; out_ready = 1'b1; start1 = 1'b0; out_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", AddrB, 0);
    check("rst_data", out_data, 0);
    check("rst_sum", sum, 0);
    check("rst1_busy", busy1, 0);
    Reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Plain pass with an explicit cycle-by-cycle timeline.
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      check("t1_valid", out_valid, (c <= 24 && c % 3 == 0) ? 1 : 0);
      check("t1_addr", AddrB, (c <= 24) ? (c - 1) / 3 : 7);
      if (c <= 24 && c % 3 == 0) check("t1_data", out_data, 8'h10 + 8'(c / 3 - 1));
      check("t1_done", done, (c == 25) ? 1 : 0);
      check("t1_busy", busy, (c <= 25) ? 1 : 0);
      if (c < 26) tick();
    end
    check("t1_sum", sum, c_CK ? 11'h09C : 11'h000);

    // Stall 5 cycles on word 3.
    start = 1'b1; tick(); start = 1'b0;
    run_pass("t2", 1'b0, 3, 5, 0);
    check("t2_sum_const", sum, c_CK ? 11'h09C : 11'h000);

    // start pulsed mid-pass must be ignored.
    start = 1'b1; tick(); start = 1'b0;
    run_pass("t3", 1'b0, -1, 0, 10);

    // Asynchronous reset while presenting word 5.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 40 && !(out_valid && AddrB == 3'd5); k++) tick();
    check("t4_reached", out_valid && AddrB == 3'd5, 1);
    Reset = 1'b1;
    #1;
    check("t4_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_addr", AddrB, 0);
    check("t4_data", out_data, 0);
    check("t4_sum", sum, 0);
    @(posedge clk); #1;
    Reset = 1'b0;
    tick();
    check("t4_idle", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    run_pass("t4b", 1'b0, -1, 0, 0);

    // start held high across two back-to-back passes of 0xFF.
    for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
    start = 1'b1; tick();
    run_pass("t5a", 1'b1, -1, 0, 0);
    check("t5a_sum", sum, c_CK ? 11'h7F8 : 11'h000);
    tick();
    check("t5_restart_busy", busy, 1);
    check("t5_restart_sum", sum, 0);
    run_pass("t5b", 1'b1, -1, 0, 0);
    check("t5b_sum", sum, c_CK ? 11'h7F8 : 11'h000);
    start = 1'b0;
    tick();
    check("t5_stop", busy, 0);

    // DEPTH=1 instance.
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("t6_c1_busy", busy1, 1);
    check("t6_c1_valid", out_valid1, 0);
    tick();
    check("t6_c2_valid", out_valid1, 0);
    tick();
    check("t6_c3_valid", out_valid1, 1);
    check("t6_c3_data", out_data1, 8'hA5);
    check("t6_c3_addr", AddrB1, 0);
    tick();
    check("t6_c4_done", done1, 1);
    check("t6_c4_busy", busy1, 1);
    check("t6_c4_valid", out_valid1, 0);
    tick();
    check("t6_c5_busy", busy1, 0);
    check("t6_c5_done", done1, 0);
    check("t6_sum", sum1, c_CK ? 11'h0A5 : 11'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
